// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime-programmable frame format (5-8 data bits,
// none/odd/even parity, 1 or 2 stop bits) feeding a first-word-fall-through
// receive FIFO. Each FIFO entry holds {ferr, perr, data}.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [15:0]      baud_div_i,
    input  logic [1:0]       data_bits_i,
    input  logic [1:0]       parity_i,
    input  logic             stop2_i,
    input  logic             rx_i,
    input  logic             re_i,
    input  logic             clr_overrun_i,
    output logic [7:0]       data_o,
    output logic             perr_o,
    output logic             ferr_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overrun_o
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_rxs_d;
    logic        w_rxs;
    logic        w_fall;

    // Frame configuration captured at the start edge
    logic [15:0] r_baud;
    logic [1:0]  r_dbits;
    logic        r_par_en;
    logic        r_par_odd;
    logic        r_stop2;

    logic [15:0] r_cnt;
    logic [2:0]  r_bitcnt;
    logic [7:0]  r_data;
    logic        r_pacc;
    logic        r_perr;
    logic        r_ferr;

    logic        w_sample;
    logic        w_last_bit;
    logic [16:0] w_p_full;
    logic [15:0] w_half_m1;
    logic        w_push;
    logic        w_frame_ferr;

    logic [9:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overrun;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_wr;
    logic             w_ovf;

    assign w_rxs      = r_sync2;
    assign w_fall     = r_rxs_d & ~w_rxs;
    assign w_sample   = (r_cnt == '0);
    assign w_last_bit = (r_bitcnt == (3'(r_dbits) + 3'd4));
    // First sample lands floor(P/2) clocks after the edge, so load floor(P/2)-1
    assign w_p_full   = {1'b0, baud_div_i} + 17'd1;
    assign w_half_m1  = 16'((w_p_full >> 1) - 17'd1);

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
            r_rxs_d <= r_sync2;
        end
    end

    // Receiver state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Receiver next state, push strobe and framing error of the completed frame
    always_comb begin
        w_state_nxt  = r_state;
        w_push       = 1'b0;
        w_frame_ferr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_sample) w_state_nxt = w_rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_sample && w_last_bit) w_state_nxt = r_par_en ? S_PARITY : S_STOP1;
            end
            S_PARITY: begin
                if (w_sample) w_state_nxt = S_STOP1;
            end
            S_STOP1: begin
                w_frame_ferr = ~w_rxs;
                if (w_sample) begin
                    if (r_stop2) begin
                        w_state_nxt = S_STOP2;
                    end else begin
                        w_push      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_STOP2: begin
                w_frame_ferr = r_ferr | ~w_rxs;
                if (w_sample) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Receiver datapath: config latch, bit timing, shift register, error flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_baud    <= '0;
            r_dbits   <= '0;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_stop2   <= 1'b0;
            r_cnt     <= '0;
            r_bitcnt  <= '0;
            r_data    <= '0;
            r_pacc    <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_fall) begin
                r_baud    <= baud_div_i;
                r_dbits   <= data_bits_i;
                r_par_en  <= (parity_i == 2'd1) || (parity_i == 2'd2);
                r_par_odd <= (parity_i == 2'd1);
                r_stop2   <= stop2_i;
                r_cnt     <= w_half_m1;
                r_bitcnt  <= '0;
                r_data    <= '0;
                r_pacc    <= 1'b0;
                r_perr    <= 1'b0;
                r_ferr    <= 1'b0;
            end
        end else begin
            r_cnt <= w_sample ? r_baud : r_cnt - 16'd1;
            if (w_sample) begin
                case (r_state)
                    S_DATA: begin
                        r_data[r_bitcnt] <= w_rxs;
                        r_pacc           <= r_pacc ^ w_rxs;
                        r_bitcnt         <= r_bitcnt + 3'd1;
                    end
                    S_PARITY: r_perr <= r_par_odd ? ~(r_pacc ^ w_rxs) : (r_pacc ^ w_rxs);
                    S_STOP1:  r_ferr <= ~w_rxs;
                    default:  ;
                endcase
            end
        end
    end

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = re_i & ~w_empty;
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_ovf   = w_push & w_full & ~w_pop;

    // FIFO storage, intentionally not reset
    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wptr] <= {w_frame_ferr, r_perr, r_data};
    end

    // FIFO pointers, occupancy and sticky overrun (set wins over clear)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_ovf) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun_i) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign {ferr_o, perr_o, data_o} = r_mem[r_rptr];
    assign empty_o   = w_empty;
    assign full_o    = w_full;
    assign count_o   = r_count;
    assign overrun_o = r_overrun;

endmodule
